// File: rtl/register_file_pn_pkg.sv
// Shared types and constants for the parametrised register file:
// read-engine states, fixed register indices and bus-select offsets.
package regfile_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } rd_state_e;

    localparam int PC_IDX = 0;
    localparam int AC_IDX = 1;

    // DR and IR sit directly above the array registers on the B-bus select
    function automatic int sel_dr(input int nreg);
        return nreg;
    endfunction

    function automatic int sel_ir(input int nreg);
        return nreg + 1;
    endfunction

endpackage

// File: rtl/register_file_pn_if.sv
// Memory read handshake between the register file (master) and data RAM (slave).
interface register_file_pn_if #(
    parameter int WIDTH = 16
) ();
    logic             mem_req;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/register_file_pn_reg_inc_dec.sv
// One datapath register with synchronous reset, parallel load and
// increment/decrement; load beats inc/dec, and inc with dec together holds.
module reg_inc_dec #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = d;
        end else if (inc ^ dec) begin
            q_d = inc ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/register_file_pn.sv
// Processor register file: NREG inc/dec registers plus DR, AR and IR,
// a B-bus select mux and a request/acknowledge engine that fills DR from RAM.
module register_file_pn
    import regfile_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int OPC_W = 6,
    parameter int SEL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   c_bus,
    input  logic [NREG+1:0]    c_we,
    input  logic [NREG-1:0]    inc,
    input  logic [NREG-1:0]    dec,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   bus_out,
    output logic               ac_zero,
    input  logic               ld_ir,
    output logic [OPC_W-1:0]   opcode,
    input  logic               rd_start,
    register_file_pn_if.master mem,
    output logic               rd_busy,
    output logic               rd_done
);

    logic [WIDTH-1:0] reg_val [NREG];

    rd_state_e        state_q,    state_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic             rd_done_q,  rd_done_d;
    logic [WIDTH-1:0] dr_q,       dr_d;
    logic [WIDTH-1:0] ar_q,       ar_d;
    logic [WIDTH-1:0] ir_q,       ir_d;

    for (genvar i = 0; i < NREG; i++) begin : g_regs
        reg_inc_dec #(
            .WIDTH (WIDTH)
        ) u_reg (
            .clk (clk),
            .rst (rst),
            .ld  (c_we[i]),
            .d   (c_bus),
            .inc (inc[i]),
            .dec (dec[i]),
            .q   (reg_val[i])
        );
    end

    // Memory capture into DR overrides a same-cycle write from the C-bus
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        rd_done_d  = 1'b0;
        dr_d       = dr_q;
        ar_d       = ar_q;
        ir_d       = ir_q;

        if (c_we[NREG]) begin
            dr_d = c_bus;
        end
        if (c_we[NREG+1]) begin
            ar_d = c_bus;
        end
        if (ld_ir) begin
            ir_d = dr_q;
        end

        case (state_q)
            IDLE: begin
                if (rd_start) begin
                    mem_addr_d = ar_q;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    dr_d      = mem.mem_rdata;
                    rd_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            rd_done_q  <= 1'b0;
            dr_q       <= '0;
            ar_q       <= '0;
            ir_q       <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            rd_done_q  <= rd_done_d;
            dr_q       <= dr_d;
            ar_q       <= ar_d;
            ir_q       <= ir_d;
        end
    end

    // Unused select codes fall through to zero
    always_comb begin
        bus_out = '0;
        for (int i = 0; i < NREG; i++) begin
            if (sel == SEL_W'(i)) begin
                bus_out = reg_val[i];
            end
        end
        if (sel == SEL_W'(sel_dr(NREG))) begin
            bus_out = dr_q;
        end
        if (sel == SEL_W'(sel_ir(NREG))) begin
            bus_out = ir_q;
        end
    end

    assign ac_zero      = (reg_val[AC_IDX] == '0);
    assign opcode       = ir_q[OPC_W-1:0];
    assign mem.mem_req  = (state_q == REQ);
    assign mem.mem_addr = mem_addr_q;
    assign rd_busy      = (state_q == REQ);
    assign rd_done      = rd_done_q;

endmodule
